attn_seq_controller: RTL

ATTN_SEQ_CONTROLLER -- requirements
Module: attn_seq_controller

---
 rtl/attn_seq_controller_pkg.sv | 11 +
 rtl/attn_seq_controller_seq_addr_cnt.sv | 19 +
 rtl/attn_seq_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/attn_seq_controller_pkg.sv
// attn_seq_controller shared types and defaults
package attn_seq_controller_pkg;
  localparam int COL_DEF = 8;
  localparam int TOTAL_CYCLE_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_BLK_DEF = 1;

  typedef enum logic [2:0] {
    IDLE, KWR, LOAD, EXEC, SFU, DONE
  } state_t;
endpackage

// File: rtl/attn_seq_controller_seq_addr_cnt.sv
// Loadable, enable-gated wrapping address counter
module seq_addr_cnt
  import attn_seq_controller_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (ld) q <= d;
    else if (en) q <= q + W'(1);
  end
endmodule

// File: rtl/attn_seq_controller.sv
// Attention-array sequencer: K write, K/Q load, execute, SFU drain
module attn_seq_controller
  import attn_seq_controller_pkg::*;
#(
  parameter int COL         = COL_DEF,
  parameter int TOTAL_CYCLE = TOTAL_CYCLE_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_BLK     = NUM_BLK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic              kmem_wr,
  output logic              kmem_rd,
  output logic              qmem_wr,
  output logic              qmem_rd,
  output logic              pmem_wr,
  output logic [ADDR_W-1:0] kmem_add,
  output logic [ADDR_W-1:0] qmem_add,
  output logic [ADDR_W-1:0] pmem_add,
  output logic              load,
  output logic              execute,
  output logic              sfu_acc,
  output logic              sfu_div,
  output logic              ofifo_rd,
  output logic [7:0]        blk_idx,
  output logic              busy,
  output logic              done
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TOTAL_CYCLE - 1);
  localparam logic [CW-1:0] T_LEN = CW'(TOTAL_CYCLE);
  localparam logic [7:0] BLK_LAST = 8'(NUM_BLK - 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic k_ld, k_en, q_ld, q_en, p_ld, p_en, p_last;
  logic [ADDR_W-1:0] base, p_d;

  assign ofifo_rd = sfu_acc & ofifo_valid & (rd_cnt < T_LEN);
  assign base = ADDR_W'(blk_idx * TOTAL_CYCLE);

  assign k_ld = (state == KWR || state == LOAD) && cnt == COL_LAST;
  assign k_en = state == KWR || (state == LOAD && cnt < COL_LAST);
  assign q_ld = (state == LOAD || state == EXEC) && cnt == T_LAST;
  assign q_en = state == LOAD || state == EXEC;
  assign p_last = state == SFU && pmem_wr && wr_cnt == T_LAST;
  assign p_ld = (state == EXEC && cnt == T_LAST) || p_last;
  assign p_d = p_last ? '0 : base;
  assign p_en = state == SFU && pmem_wr;

  seq_addr_cnt #(.W(ADDR_W)) u_kcnt (
    .clk(clk), .reset(reset), .ld(k_ld),
    .d('0), .en(k_en), .q(kmem_add)
  );
  seq_addr_cnt #(.W(ADDR_W)) u_qcnt (
    .clk(clk), .reset(reset), .ld(q_ld),
    .d('0), .en(q_en), .q(qmem_add)
  );
  seq_addr_cnt #(.W(ADDR_W)) u_pcnt (
    .clk(clk), .reset(reset), .ld(p_ld),
    .d(p_d), .en(p_en), .q(pmem_add)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      blk_idx <= '0;
      kmem_wr <= 1'b0;
      kmem_rd <= 1'b0;
      qmem_wr <= 1'b0;
      qmem_rd <= 1'b0;
      pmem_wr <= 1'b0;
      load <= 1'b0;
      execute <= 1'b0;
      sfu_acc <= 1'b0;
      sfu_div <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      pmem_wr <= ofifo_rd;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= KWR;
            cnt <= '0;
            blk_idx <= '0;
            kmem_wr <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        KWR: begin
          if (cnt == COL_LAST) begin
            state <= LOAD;
            cnt <= '0;
            kmem_wr <= 1'b0;
            qmem_wr <= 1'b1;
            kmem_rd <= 1'b1;
            load <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD: begin
          if (cnt == COL_LAST) begin
            kmem_rd <= 1'b0;
            load <= 1'b0;
          end
          if (cnt == T_LAST) begin
            state <= EXEC;
            cnt <= '0;
            qmem_wr <= 1'b0;
            qmem_rd <= 1'b1;
            execute <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EXEC: begin
          if (cnt == T_LAST) begin
            state <= SFU;
            cnt <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            qmem_rd <= 1'b0;
            execute <= 1'b0;
            sfu_acc <= 1'b1;
            sfu_div <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SFU: begin
          if (ofifo_rd) rd_cnt <= rd_cnt + CW'(1);
          if (pmem_wr) wr_cnt <= wr_cnt + CW'(1);
          // last write of the block closes SFU
          if (p_last) begin
            sfu_acc <= 1'b0;
            sfu_div <= 1'b0;
            if (blk_idx != BLK_LAST) begin
              blk_idx <= blk_idx + 8'd1;
              state <= KWR;
              cnt <= '0;
              kmem_wr <= 1'b1;
            end else begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
